pixie_video_dma_engine: RTL and testbench

- Parametrised successor to the Pixie display DMA front end: CDP1861/1864-class video timing generator and DMA capture engine.
- Generates raster counters, EF/INT timing, per-line DMA requests and a frame-buffer write stream. Adds programmable window geometry, selectable line-repeat (vertical resolution) modes, a per-line byte-count handshake and sticky DMA error flags.
- Sits between the 1802 core (SC state, data bus) and the video frame-buffer RAM.

---
 rtl/pixie_pkg.sv | 42 ++++
 rtl/pixie_raster_timer.sv | 74 +++++++
 rtl/pixie_video_dma_engine.sv | 161 ++++++++++++++++
 tb/tb_pixie_video_dma_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pixie_pkg.sv
// Shared definitions for the Pixie display front end and back end:
// 1802 state codes, line-repeat encodings and default raster geometry.
package pixie_pkg;

    typedef enum logic [1:0] {
        SC_FETCH = 2'b00,
        SC_EXEC  = 2'b01,
        SC_DMA   = 2'b10,
        SC_INT   = 2'b11
    } sc_t;

    typedef enum logic [1:0] {
        REP_X1 = 2'b00,
        REP_X2 = 2'b01,
        REP_X4 = 2'b10,
        REP_X8 = 2'b11
    } rep_t;

    localparam int DEF_BYTES_PER_LINE  = 14;
    localparam int DEF_LINES_PER_FRAME = 262;
    localparam int DEF_ACTIVE_FIRST    = 80;
    localparam int DEF_ACTIVE_LINES    = 128;
    localparam int DEF_DMA_START       = 1;
    localparam int DEF_DMA_BYTES       = 8;
    localparam int DEF_EF_LEAD         = 4;
    localparam int DEF_INT_LEAD        = 2;
    localparam int DEF_ADDR_W          = 10;

    // Last value of the per-row repeat counter (N-1 for N = 1 << cfg).
    function automatic logic [2:0] rep_last(input rep_t cfg);
        logic [2:0] last;
        case (cfg)
            REP_X1:  last = 3'd0;
            REP_X2:  last = 3'd1;
            REP_X4:  last = 3'd3;
            REP_X8:  last = 3'd7;
            default: last = 3'd0;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/pixie_raster_timer.sv
// Raster timing: horizontal/vertical counters plus per-line flags.
// Line flags are loaded at the end of the previous line from the next
// v_cnt value, so each flag covers exactly the line it describes.
module pixie_raster_timer
    import pixie_pkg::*;
#(
    parameter int BYTES_PER_LINE  = DEF_BYTES_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int ACTIVE_FIRST    = DEF_ACTIVE_FIRST,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int EF_LEAD         = DEF_EF_LEAD,
    parameter int INT_LEAD        = DEF_INT_LEAD,
    parameter int H_W             = $clog2(BYTES_PER_LINE),
    parameter int V_W             = $clog2(LINES_PER_FRAME)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clk_enable,
    input  logic           enabled,
    output logic [H_W-1:0] h_cnt,
    output logic           h_end,
    output logic           v_end,
    output logic           efx,
    output logic           int_pixie,
    output logic           v_active
);

    localparam int ACTIVE_END = ACTIVE_FIRST + ACTIVE_LINES;
    localparam logic [H_W-1:0] H_LAST = H_W'(BYTES_PER_LINE - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(LINES_PER_FRAME - 1);
    localparam logic [V_W-1:0] V_EF0  = V_W'(ACTIVE_FIRST - EF_LEAD);
    localparam logic [V_W-1:0] V_INT0 = V_W'(ACTIVE_FIRST - INT_LEAD);
    localparam logic [V_W-1:0] V_ACT0 = V_W'(ACTIVE_FIRST);
    localparam logic [V_W-1:0] V_EF1  = V_W'(ACTIVE_END - EF_LEAD);
    localparam logic [V_W-1:0] V_ACT1 = V_W'(ACTIVE_END);

    logic [V_W-1:0] v_cnt;
    logic [V_W-1:0] v_next;
    logic           efx_next;
    logic           int_next;
    logic           act_next;

    assign h_end = (h_cnt == H_LAST);
    assign v_end = (v_cnt == V_LAST);

    // Next line number and the flags that line will carry.
    always_comb begin
        v_next   = v_end ? '0 : v_cnt + V_W'(1);
        efx_next = ((v_next >= V_EF0) && (v_next < V_ACT0)) ||
                   ((v_next >= V_EF1) && (v_next < V_ACT1));
        int_next = enabled && (v_next >= V_INT0) && (v_next < V_ACT0);
        act_next = enabled && (v_next >= V_ACT0) && (v_next < V_ACT1);
    end

    // Counters advance per machine cycle; line flags load at line end.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            efx       <= 1'b0;
            int_pixie <= 1'b0;
            v_active  <= 1'b0;
        end else if (clk_enable) begin
            h_cnt <= h_end ? '0 : h_cnt + H_W'(1);
            if (h_end) begin
                v_cnt     <= v_next;
                efx       <= efx_next;
                int_pixie <= int_next;
                v_active  <= act_next;
            end
        end
    end

endmodule

// File: rtl/pixie_video_dma_engine.sv
// Pixie video DMA engine: raster timing, per-line DMA requests, the
// frame-buffer write stream with line repeat, and sticky DMA error flags.
module pixie_video_dma_engine
    import pixie_pkg::*;
#(
    parameter int BYTES_PER_LINE  = DEF_BYTES_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int ACTIVE_FIRST    = DEF_ACTIVE_FIRST,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int DMA_START       = DEF_DMA_START,
    parameter int DMA_BYTES       = DEF_DMA_BYTES,
    parameter int EF_LEAD         = DEF_EF_LEAD,
    parameter int INT_LEAD        = DEF_INT_LEAD,
    parameter int ADDR_W          = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    input  logic [1:0]        sc,
    input  logic              disp_on,
    input  logic              disp_off,
    input  logic [1:0]        line_rep,
    input  logic [7:0]        data,
    output logic              dmao,
    output logic              int_pixie,
    output logic              efx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr_en,
    output logic              frame_start,
    output logic              dma_underrun,
    output logic              dma_overrun
);

    localparam int H_W = $clog2(BYTES_PER_LINE);
    localparam int V_W = $clog2(LINES_PER_FRAME);
    localparam int B_W = $clog2(DMA_BYTES + 1);
    localparam logic [H_W-1:0]    H_LO  = H_W'(DMA_START);
    localparam logic [H_W-1:0]    H_HI  = H_W'(DMA_START + DMA_BYTES);
    localparam logic [B_W-1:0]    QUOTA = B_W'(DMA_BYTES);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(DMA_BYTES);

    logic              enabled;
    logic [H_W-1:0]    h_cnt;
    logic              h_end;
    logic              v_end;
    logic              v_active;
    logic [B_W-1:0]    byte_cnt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] next_base;
    logic [2:0]        rep_cnt;
    rep_t              rep_cfg;
    logic              quota_open;
    logic              in_slot;
    logic              xfer;
    logic              wrap;
    logic              line_done;
    logic              disable_now;

    pixie_raster_timer #(
        .BYTES_PER_LINE  (BYTES_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .ACTIVE_FIRST    (ACTIVE_FIRST),
        .ACTIVE_LINES    (ACTIVE_LINES),
        .EF_LEAD         (EF_LEAD),
        .INT_LEAD        (INT_LEAD),
        .H_W             (H_W),
        .V_W             (V_W)
    ) u_raster (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .enabled    (enabled),
        .h_cnt      (h_cnt),
        .h_end      (h_end),
        .v_end      (v_end),
        .efx        (efx),
        .int_pixie  (int_pixie),
        .v_active   (v_active)
    );

    assign quota_open  = (byte_cnt < QUOTA);
    assign in_slot     = (h_cnt >= H_LO) && (h_cnt < H_HI);
    assign xfer        = clk_enable && enabled && v_active && (sc == SC_DMA) && quota_open;
    assign wrap        = clk_enable && h_end && v_end;
    assign line_done   = clk_enable && h_end;
    assign disable_now = clk_enable && disp_off && !disp_on;
    assign next_base   = line_base + STEP;

    // Request and write strobes are combinational so the CPU sees dmao
    // drop in the very cycle the quota is met or the display is disabled.
    assign dmao        = enabled && v_active && in_slot && quota_open;
    assign mem_wr_en   = xfer;
    assign mem_addr    = addr_cnt;
    assign mem_data    = data;
    assign frame_start = wrap;

    // Display enable: disp_on takes priority over disp_off.
    always_ff @(posedge clk) begin
        if (reset) begin
            enabled <= 1'b0;
        end else if (clk_enable) begin
            if (disp_on) begin
                enabled <= 1'b1;
            end else if (disp_off) begin
                enabled <= 1'b0;
            end
        end
    end

    // Sticky DMA error flags; a disable clears them and wins over a set.
    always_ff @(posedge clk) begin
        if (reset || disable_now) begin
            dma_underrun <= 1'b0;
            dma_overrun  <= 1'b0;
        end else begin
            if (clk_enable && (sc == SC_DMA) && !xfer) begin
                dma_overrun <= 1'b1;
            end
            if (line_done && enabled && v_active && quota_open) begin
                dma_underrun <= 1'b1;
            end
        end
    end

    // Address, byte count and row-repeat bookkeeping. Line-end updates
    // override a transfer in the same cycle (the write itself still uses
    // the current addr_cnt).
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cfg   <= REP_X1;
            line_base <= '0;
            rep_cnt   <= 3'd0;
            addr_cnt  <= '0;
            byte_cnt  <= '0;
        end else if (wrap) begin
            rep_cfg   <= rep_t'(line_rep);
            line_base <= '0;
            rep_cnt   <= 3'd0;
            addr_cnt  <= '0;
            byte_cnt  <= '0;
        end else if (line_done) begin
            byte_cnt <= '0;
            if (v_active) begin
                if (rep_cnt == rep_last(rep_cfg)) begin
                    line_base <= next_base;
                    addr_cnt  <= next_base;
                    rep_cnt   <= 3'd0;
                end else begin
                    addr_cnt <= line_base;
                    rep_cnt  <= rep_cnt + 3'd1;
                end
            end
        end else if (xfer) begin
            addr_cnt <= addr_cnt + ADDR_W'(1);
            byte_cnt <= byte_cnt + B_W'(1);
        end
    end

endmodule

// File: tb/tb_pixie_video_dma_engine.sv
// Self-checking bench for pixie_video_dma_engine. A CPU model grants
// DMA cycles and pushes each expected frame-buffer write (closed-form
// address row*8+k) into a queue; a negedge monitor pops and compares.
module tb_pixie_video_dma_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clk_enable = 1'b0;
    logic [1:0] sc = 2'b00;
    logic       disp_on = 1'b0;
    logic       disp_off = 1'b0;
    logic [1:0] line_rep = 2'b00;
    logic [7:0] data = 8'h00;
    logic       dmao;
    logic       int_pixie;
    logic       efx;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wr_en;
    logic       frame_start;
    logic       dma_underrun;
    logic       dma_overrun;

    pixie_video_dma_engine dut (
        .clk          (clk),
        .reset        (reset),
        .clk_enable   (clk_enable),
        .sc           (sc),
        .disp_on      (disp_on),
        .disp_off     (disp_off),
        .line_rep     (line_rep),
        .data         (data),
        .dmao         (dmao),
        .int_pixie    (int_pixie),
        .efx          (efx),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_wr_en    (mem_wr_en),
        .frame_start  (frame_start),
        .dma_underrun (dma_underrun),
        .dma_overrun  (dma_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [17:0] exp_q[$];

    // Bench view of the raster position and expected state.
    int bh = 0, bv = 0, bk = 0, rep_cur = 0;
    int short_line = -1, extra_line = -1;
    bit en_m = 1'b0, en_line = 1'b0, exp_under = 1'b0, exp_over = 1'b0, ce_random = 1'b0;
    logic [13:0] mask = 14'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s line=%0d h=%0d got=%0h expected=%0h", name, bv, bh, act, exp);
        end
    endtask

    // Scoreboard monitor: every DUT write must match the oldest expected one.
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {22'h0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                chk("write_addr_data", {14'h0, mem_addr, mem_data}, {14'h0, exp_q.pop_front()});
            end
            pops++;
        end
    end

    // One machine-cycle slot: drive inputs, sample, clock, advance the model.
    task automatic do_cycle(input bit on, input bit off, input bit ce);
        bit act, grant, extra;
        logic [7:0] d;
        act   = en_line && en_m && bv >= 80 && bv < 208;
        grant = ce && act && bh >= 1 && bh <= 8 && bk < 8 && !(bv == short_line && bk >= 5);
        extra = ce && act && bv == extra_line && bh == 10;
        d = 8'($urandom);
        clk_enable = ce;
        disp_on    = on;
        disp_off   = off;
        data       = d;
        sc         = (grant || extra) ? 2'b10 : 2'b00;
        if (grant) begin
            exp_q.push_back({10'(((bv - 80) >> rep_cur) * 8 + bk), d});
            bk++;
        end
        if (extra) exp_over = 1'b1;
        #2;
        mask[bh] = mask[bh] | dmao;
        if (ce && bh == 0) chk("error_flags", {30'h0, dma_underrun, dma_overrun}, {30'h0, exp_under, exp_over});
        if (ce && bh == 5) chk("line_flags", {30'h0, efx, int_pixie},
                               {30'h0, ((bv >= 76 && bv < 80) || (bv >= 204 && bv < 208)),
                                en_line && (bv == 78 || bv == 79)});
        if (ce && bh == 13) begin
            chk("dmao_slots", {18'h0, mask}, act ? 32'h1FE : 32'h0);
            chk("frame_start", {31'h0, frame_start}, {31'h0, bv == 261});
            if (act) chk("line_writes_pending", exp_q.size(), 0);
            if (act && bk < 8) exp_under = 1'b1;
        end
        @(posedge clk);
        #1;
        if (ce) begin
            if (bh == 13) begin
                en_line = en_m;
                bk = 0;
                mask = 14'h0;
                bh = 0;
                if (bv == 261) begin
                    bv = 0;
                    rep_cur = int'(line_rep);
                end else begin
                    bv++;
                end
            end else begin
                bh++;
            end
            if (on) en_m = 1'b1;
            else if (off) begin
                en_m = 1'b0;
                exp_under = 1'b0;
                exp_over = 1'b0;
            end
        end
    endtask

    task automatic run_until(input int v, input int h);
        int guard;
        bit ce;
        guard = 0;
        while (!(bv == v && bh == h)) begin
            ce = ce_random ? ($urandom_range(0, 3) != 0) : 1'b1;
            do_cycle(1'b0, 1'b0, ce);
            guard++;
            if (guard > 20000) begin
                chk("run_until_timeout", guard, 0);
                break;
            end
        end
    endtask

    // Synchronous reset for one cycle, then every output must read zero.
    task automatic do_reset();
        reset = 1'b1;
        sc = 2'b00;
        disp_on = 1'b0;
        disp_off = 1'b0;
        clk_enable = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_outputs",
            {15'h0, dmao, int_pixie, efx, mem_wr_en, frame_start, dma_underrun, dma_overrun, mem_addr},
            32'h0);
        bh = 0; bv = 0; bk = 0; rep_cur = 0;
        en_m = 1'b0; en_line = 1'b0; exp_under = 1'b0; exp_over = 1'b0;
        mask = 14'h0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Frame 0: x1 repeat, full grants; request x4 for the next frame.
        do_cycle(1'b1, 1'b0, 1'b1);
        run_until(100, 0);
        line_rep = 2'b10;
        run_until(0, 0);

        // Frame 1: x4 repeat with gaps in clk_enable; the change back to
        // x1 mid-frame must not affect this frame.
        ce_random = 1'b1;
        run_until(10, 0);
        line_rep = 2'b00;
        run_until(0, 0);
        ce_random = 1'b0;

        // Frame 2: short grant on line 80, stray DMA cycle on line 90,
        // x2 requested at line 100, disable/re-enable after the window.
        short_line = 80;
        extra_line = 90;
        run_until(100, 0);
        line_rep = 2'b01;
        run_until(220, 0);
        do_cycle(1'b0, 1'b1, 1'b1);
        run_until(240, 0);
        do_cycle(1'b1, 1'b0, 1'b1);
        run_until(0, 0);
        short_line = -1;
        extra_line = -1;

        // Frame 3: x2 repeat, reset in the middle of line 150.
        run_until(150, 4);
        do_reset();

        // Post-reset frame: disabled until line 220, then enabled; writes
        // resume only at line 80 of the following frame.
        run_until(220, 0);
        do_cycle(1'b1, 1'b0, 1'b1);
        run_until(0, 0);
        run_until(90, 0);

        chk("queue_empty", exp_q.size(), 0);
        // 1024 + 1024 + (1024-3) + (70*8+3) + 0 + 10*8
        chk("total_writes", pops, 3712);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
